// File: rtl/booth_pkg.sv
// Shared Booth multiplier definitions: resolver FSM states, default datapath
// sizes and the segment-count derivation.
package booth_pkg;

  typedef enum logic [1:0] {
    CSA_IDLE = 2'd0,
    CSA_ADD  = 2'd1,
    CSA_DONE = 2'd2
  } csa_res_state_t;

  localparam int unsigned CSA_WIDTH = 128;
  localparam int unsigned CSA_SEG   = 32;

  function automatic int unsigned csa_nseg(input int unsigned width, input int unsigned seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/csa_seg_adder.sv
// One SEG-bit slice of the carry-propagate adder; the resolver reuses this
// slice every cycle with a registered carry between segments.
module csa_seg_adder #(
  parameter int unsigned SEG = 32
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           cin_i,
  output logic [SEG-1:0] sum_o,
  output logic           cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{SEG{1'b0}}, cin_i};

endmodule

// File: rtl/csa_resolver.sv
// Resolves a redundant (sum, carry) pair into one binary word, one SEG-bit
// segment per cycle. Define CSA_RESOLVER_EARLY_EXIT_EN to stop once the rest is zero.
//
//   state     | meaning
//   CSA_IDLE  | ready for a new operand pair
//   CSA_ADD   | adding segment k_q with the running carry c_q
//   CSA_DONE  | result held on out_data_o until out_ready_i
module csa_resolver
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = CSA_WIDTH,
  parameter int unsigned SEG   = CSA_SEG
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_sum_i,
  input  logic [WIDTH-1:0] in_carry_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_cout_o,
  output logic             busy_o
);

  localparam int unsigned NSEG = csa_nseg(WIDTH, SEG);
  localparam int unsigned KW   = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSEG - 1);

  if (WIDTH % SEG != 0) begin : g_bad_seg
    $error("csa_resolver: WIDTH must be a multiple of SEG");
  end

  csa_res_state_t   state_q;
  logic [KW-1:0]    k_q;
  logic             c_q;
  logic [WIDTH-1:0] sum_q, carry_q, res_q, res_d;
  logic             cout_q, in_ready_q, out_valid_q, busy_q;

  logic [SEG-1:0]   seg_a, seg_b, seg_s;
  logic             seg_co, last_seg;

  // Select the current operand segment and splice the new sum into the result
  always_comb begin
    seg_a = '0;
    seg_b = '0;
    res_d = res_q;
    for (int j = 0; j < int'(NSEG); j++) begin
      if (k_q == KW'(j)) begin
        seg_a = sum_q[j*SEG +: SEG];
        seg_b = carry_q[j*SEG +: SEG];
        res_d[j*SEG +: SEG] = seg_s;
      end
    end
  end

  csa_seg_adder #(.SEG(SEG)) u_seg (
    .a_i    (seg_a),
    .b_i    (seg_b),
    .cin_i  (c_q),
    .sum_o  (seg_s),
    .cout_o (seg_co)
  );

`ifdef CSA_RESOLVER_EARLY_EXIT_EN
  logic hi_nz;
  always_comb begin
    hi_nz = 1'b0;
    for (int j = 0; j < int'(NSEG); j++) begin
      if (KW'(j) > k_q) hi_nz = hi_nz | (|(sum_q[j*SEG +: SEG] | carry_q[j*SEG +: SEG]));
    end
  end
  // No carry and nothing left above: remaining result bits are already zero
  assign last_seg = (k_q == K_LAST) || (!seg_co && !hi_nz);
`else
  assign last_seg = (k_q == K_LAST);
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= CSA_IDLE;
      k_q         <= '0;
      c_q         <= 1'b0;
      sum_q       <= '0;
      carry_q     <= '0;
      res_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        CSA_IDLE: begin
          if (in_valid_i) begin
            sum_q      <= in_sum_i;
            carry_q    <= in_carry_i;
            res_q      <= '0;
            k_q        <= '0;
            c_q        <= 1'b0;
            cout_q     <= 1'b0;
            state_q    <= CSA_ADD;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        CSA_ADD: begin
          res_q <= res_d;
          c_q   <= seg_co;
          k_q   <= k_q + KW'(1);
          if (last_seg) begin
            cout_q      <= seg_co;
            state_q     <= CSA_DONE;
            out_valid_q <= 1'b1;
          end
        end
        CSA_DONE: begin
          if (out_ready_i) begin
            state_q     <= CSA_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= CSA_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign out_data_o  = res_q;
  assign out_cout_o  = cout_q;

endmodule
